// File: rtl/keyscan_if.sv
// Matrix-side and result signals of the key scanner, bundled for port use.
interface keyscan_if;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [15:0] keys;
    logic        key_down;
    logic        key_up;

    // Consumer side: drives the column returns, observes scan results.
    modport master (
        output col_in,
        input  row_out,
        input  keys,
        input  key_down,
        input  key_up
    );

    // Scanner side.
    modport slave (
        input  col_in,
        output row_out,
        output keys,
        output key_down,
        output key_up
    );
endinterface

// File: rtl/keyscan.sv
// 4x4 active-low key matrix scanner with column synchronizer, whole-frame
// debounce, registered pressed-key vector and one-cycle press/release strobes.
module keyscan #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic     clk,
    input  logic     reset,
    keyscan_if.slave kif
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic [3:0]       col_s1;
    logic [3:0]       col_s2;
    logic [DIV_W-1:0] div;
    logic [1:0]       row;
    logic [1:0]       row_next;
    logic [3:0]       row_out_q;
    // Rows 0..2 only; row 3 feeds the completed frame directly.
    logic [11:0]      frame;
    logic [15:0]      last;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [15:0]      keys_q;
    logic             key_down_q;
    logic             key_up_q;

    logic [3:0]       sample;
    logic             row_end;
    logic             frame_end;
    logic [15:0]      full;
    logic             update;

    assign kif.row_out  = row_out_q;
    assign kif.keys     = keys_q;
    assign kif.key_down = key_down_q;
    assign kif.key_up   = key_up_q;

    // Two-flop synchronizer on the asynchronous column returns.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_s1 <= '1;
            col_s2 <= '1;
        end else begin
            col_s1 <= kif.col_in;
            col_s2 <= col_s1;
        end
    end

    // Sample point, frame assembly and debounce count decision.
    always_comb begin
        sample    = ~col_s2;
        row_end   = (div == DIV_LAST);
        frame_end = row_end && (row == 2'd3);
        row_next  = row + 2'd1;
        full      = {sample, frame};
        cnt_next  = '0;
        if (full == last) begin
            cnt_next = (cnt == CNT_LAST) ? cnt : cnt + CNT_W'(1);
        end
        update    = frame_end && (cnt_next == CNT_LAST);
    end

    // Divider, row counter, row drive and per-row capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            div       <= '0;
            row       <= '0;
            row_out_q <= 4'b1110;
            frame     <= '0;
        end else begin
            div <= row_end ? '0 : div + DIV_W'(1);
            if (row_end) begin
                row       <= row_next;
                row_out_q <= ~(4'b0001 << row_next);
                case (row)
                    2'd0:    frame[3:0]  <= sample;
                    2'd1:    frame[7:4]  <= sample;
                    2'd2:    frame[11:8] <= sample;
                    default: ;
                endcase
            end
        end
    end

    // Frame comparison, debounce counter, key vector and strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            last       <= '0;
            cnt        <= '0;
            keys_q     <= '0;
            key_down_q <= 1'b0;
            key_up_q   <= 1'b0;
        end else begin
            key_down_q <= 1'b0;
            key_up_q   <= 1'b0;
            if (frame_end) begin
                last <= full;
                cnt  <= cnt_next;
            end
            if (update) begin
                keys_q     <= full;
                key_down_q <= |(full & ~keys_q);
                key_up_q   <= |(~full & keys_q);
            end
        end
    end
endmodule

// File: tb/tb_keyscan.sv
// Directed bench for keyscan: a key-matrix model drives the column returns
// from the row drive; expected values are hand-derived cycle positions.
module tb_keyscan;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [15:0] matrix0 = '0;
    logic [15:0] matrix1 = '0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dn0 = 0, up0 = 0, dn1 = 0, up1 = 0;

    keyscan_if kif0 ();
    keyscan_if kif1 ();

    keyscan #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk   (clk),
        .reset (reset),
        .kif   (kif0)
    );

    keyscan #(.SCAN_DIV(4), .DEBOUNCE(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .kif   (kif1)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] pressed_cols(input logic [3:0] rows, input logic [15:0] m);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (!rows[i]) r = r | m[4*i +: 4];
        end
        return r;
    endfunction

    // Matrix model: a pressed key shorts its column to the driven (low) row.
    always_comb begin
        kif0.col_in = ~pressed_cols(kif0.row_out, matrix0);
        kif1.col_in = ~pressed_cols(kif1.row_out, matrix1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        dn0 += int'(kif0.key_down);
        up0 += int'(kif0.key_up);
        dn1 += int'(kif1.key_down);
        up1 += int'(kif1.key_up);
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        dn0 = 0; up0 = 0; dn1 = 0; up1 = 0;
    endtask

    initial begin
        // 1: reset and scan pattern
        matrix0 = '0;
        matrix1 = '0;
        do_reset();
        for (int c = 0; c < 32; c++) begin
            chk("t1_row_out", {28'd0, kif0.row_out}, {28'd0, ~(4'b0001 << ((c / 4) % 4))});
            chk("t1_keys_strobes", {14'd0, kif0.keys, kif0.key_down, kif0.key_up}, 32'd0);
            step();
        end

        // 2: single press of key 5 in frames 1..5, then release
        do_reset();
        step_to(16);
        matrix0 = 16'h0020;
        step_to(48);
        chk("t2_keys_before", {16'd0, kif0.keys}, 32'h0000);
        step_to(64);
        chk("t2_keys_press", {16'd0, kif0.keys}, 32'h0020);
        chk("t2_down_pulse", {31'd0, kif0.key_down}, 32'd1);
        chk("t2_up_at_press", {31'd0, kif0.key_up}, 32'd0);
        step();
        chk("t2_down_cleared", {31'd0, kif0.key_down}, 32'd0);
        step_to(96);
        chk("t2_down_count", dn0, 32'd1);
        chk("t2_up_count_held", up0, 32'd0);
        matrix0 = '0;
        step_to(143);
        chk("t2_keys_still_held", {16'd0, kif0.keys}, 32'h0020);
        step();
        chk("t2_keys_release", {16'd0, kif0.keys}, 32'h0000);
        chk("t2_up_pulse", {31'd0, kif0.key_up}, 32'd1);
        step_to(160);
        chk("t2_up_count", up0, 32'd1);
        chk("t2_down_count_end", dn0, 32'd1);

        // 3: bounce rejection on key 5
        do_reset();
        step_to(16);
        matrix0 = 16'h0020;
        step_to(48);
        for (int f = 3; f <= 8; f++) begin
            matrix0 = (f % 2 == 0) ? 16'h0020 : 16'h0000;
            step_to(16 * (f + 1));
            chk("t3_keys_zero", {16'd0, kif0.keys}, 32'h0000);
        end
        chk("t3_no_strobes", dn0 + up0, 32'd0);

        // 4: keys 0 and 15 together, then release key 0
        matrix0 = 16'h8001;
        do_reset();
        step_to(47);
        chk("t4_keys_before", {16'd0, kif0.keys}, 32'h0000);
        step();
        chk("t4_keys_pair", {16'd0, kif0.keys}, 32'h8001);
        chk("t4_down_pulse", {31'd0, kif0.key_down}, 32'd1);
        matrix0 = 16'h8000;
        step_to(95);
        chk("t4_keys_pair_held", {16'd0, kif0.keys}, 32'h8001);
        step();
        chk("t4_keys_one_left", {16'd0, kif0.keys}, 32'h8000);
        chk("t4_up_pulse", {31'd0, kif0.key_up}, 32'd1);
        chk("t4_down_at_release", {31'd0, kif0.key_down}, 32'd0);
        step_to(112);
        chk("t4_down_count", dn0, 32'd1);
        chk("t4_up_count", up0, 32'd1);

        // 5: reset at row 2, div 1 while key 5 is reported
        matrix0 = 16'h0020;
        do_reset();
        step_to(57);
        chk("t5_keys_before_reset", {16'd0, kif0.keys}, 32'h0020);
        chk("t5_row_before_reset", {28'd0, kif0.row_out}, 32'hB);
        reset = 1'b1;
        step();
        chk("t5_keys_after_reset", {16'd0, kif0.keys}, 32'h0000);
        chk("t5_row_after_reset", {28'd0, kif0.row_out}, 32'hE);
        chk("t5_no_strobe", {30'd0, kif0.key_down, kif0.key_up}, 32'd0);
        reset = 1'b0;
        cyc = 0;
        dn0 = 0; up0 = 0;
        step_to(47);
        chk("t5_keys_recovering", {16'd0, kif0.keys}, 32'h0000);
        step();
        chk("t5_keys_restored", {16'd0, kif0.keys}, 32'h0020);
        chk("t5_down_restored", {31'd0, kif0.key_down}, 32'd1);

        // 6: DEBOUNCE=1 instance, key 10 for one frame
        matrix0 = '0;
        matrix1 = '0;
        do_reset();
        step_to(16);
        matrix1 = 16'h0400;
        step_to(31);
        chk("t6_keys_before", {16'd0, kif1.keys}, 32'h0000);
        step();
        chk("t6_keys_press", {16'd0, kif1.keys}, 32'h0400);
        chk("t6_down_pulse", {31'd0, kif1.key_down}, 32'd1);
        matrix1 = '0;
        step_to(48);
        chk("t6_keys_release", {16'd0, kif1.keys}, 32'h0000);
        chk("t6_up_pulse", {31'd0, kif1.key_up}, 32'd1);
        step_to(64);
        chk("t6_down_count", dn1, 32'd1);
        chk("t6_up_count", up1, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
